// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled serial input, majority-of-three bit decision,
// start + 8 data (LSB first) + optional parity + stop, ready/ack handshake with error flags.
module uart_rx #(
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_uart,
   input  logic       enable_rx,
   input  logic       rxd,
   input  logic       rx_ack,
   output logic [7:0] d_out,
   output logic       rx_valid,
   output logic       rx_ready,
   output logic       receiving,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic       r_sync1;
   logic       r_sync2;
   logic       r_syncPrev;
   logic [2:0] r_state;
   logic [3:0] r_cnt;
   logic [2:0] r_bitCnt;
   logic [7:0] r_shift;
   logic       r_s7;
   logic       r_s8;
   logic       r_parBit;
   logic [7:0] r_dOut;
   logic       r_rxValid;
   logic       r_rxReady;
   logic       r_receiving;
   logic       r_frameErr;
   logic       r_parityErr;
   logic       r_overrun;

   logic       w_fall;
   logic       w_maj;
   logic       w_parErr;

   // rxd is asynchronous; two flops for metastability, a third for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_syncPrev <= 1'b1;
      end else begin
         r_sync1    <= rxd;
         r_sync2    <= r_sync1;
         r_syncPrev <= r_sync2;
      end
   end

   assign w_fall   = r_syncPrev & ~r_sync2;
   assign w_maj    = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
   assign w_parErr = PARITY_EN && ((^r_shift ^ r_parBit) != PARITY_ODD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_bitCnt    <= 3'd0;
         r_shift     <= 8'h00;
         r_s7        <= 1'b1;
         r_s8        <= 1'b1;
         r_parBit    <= 1'b0;
         r_dOut      <= 8'h00;
         r_rxValid   <= 1'b0;
         r_rxReady   <= 1'b0;
         r_receiving <= 1'b0;
         r_frameErr  <= 1'b0;
         r_parityErr <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_rxValid <= 1'b0;
         if (rx_ack) begin
            r_rxReady <= 1'b0;
            r_overrun <= 1'b0;
         end
         if (!enable_rx) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_receiving <= 1'b0;
         end else if (r_state == S_IDLE) begin
            if (w_fall) begin
               r_state     <= S_START;
               r_cnt       <= 4'd0;
               r_bitCnt    <= 3'd0;
               r_receiving <= 1'b1;
            end
         end else if (baud_uart) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd7) r_s7 <= r_sync2;
            if (r_cnt == 4'd8) r_s8 <= r_sync2;
            case (r_state)
               S_START: begin
                  if (r_cnt == 4'd9 && w_maj) begin
                     r_state     <= S_IDLE;
                     r_receiving <= 1'b0;
                  end else if (r_cnt == 4'd15) begin
                     r_state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (r_cnt == 4'd9) r_shift <= {w_maj, r_shift[7:1]};
                  if (r_cnt == 4'd15) begin
                     r_bitCnt <= r_bitCnt + 3'd1;
                     if (r_bitCnt == 3'd7) r_state <= PARITY_EN ? S_PARITY : S_STOP;
                  end
               end
               S_PARITY: begin
                  if (r_cnt == 4'd9) r_parBit <= w_maj;
                  if (r_cnt == 4'd15) r_state <= S_STOP;
               end
               S_STOP: begin
                  // Decide at mid-stop so a back-to-back start edge is not missed
                  if (r_cnt == 4'd9) begin
                     r_dOut      <= r_shift;
                     r_frameErr  <= ~w_maj;
                     r_parityErr <= w_parErr;
                     r_rxValid   <= 1'b1;
                     r_rxReady   <= 1'b1;
                     r_overrun   <= (r_overrun | r_rxReady) & ~rx_ack;
                     r_state     <= S_IDLE;
                     r_cnt       <= 4'd0;
                     r_receiving <= 1'b0;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign d_out      = r_dOut;
   assign rx_valid   = r_rxValid;
   assign rx_ready   = r_rxReady;
   assign receiving  = r_receiving;
   assign frame_err  = r_frameErr;
   assign parity_err = r_parityErr;
   assign overrun    = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames, scoreboard queue
// filled by the stimulus and drained by a monitor on every rx_valid pulse.
module tb_uart_rx;
   localparam bit PARITY_ODD = 1'b0;

   logic       clk;
   logic       rst_n;
   logic       baud_uart;
   logic       enable_rx;
   logic       rxd;
   logic       rx_ack;
   logic [7:0] d_out;
   logic       rx_valid;
   logic       rx_ready;
   logic       receiving;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      logic       ov;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   total = 0;
   int   bad = 0;
   int   baudDiv = 0;
   bit   prevValid = 1'b0;
   bit   pending = 1'b0;

   uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(PARITY_ODD)) dut (
      .clk(clk), .rst_n(rst_n), .baud_uart(baud_uart), .enable_rx(enable_rx),
      .rxd(rxd), .rx_ack(rx_ack), .d_out(d_out), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .receiving(receiving), .frame_err(frame_err),
      .parity_err(parity_err), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One baud tick every 4 clk cycles, changed on negedge so it is stable at posedge
   initial baud_uart = 1'b0;
   always @(negedge clk) begin
      baudDiv   = (baudDiv + 1) % 4;
      baud_uart = (baudDiv == 0);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         checkOutput("validWidth", {31'd0, prevValid}, 32'd0);
         checkOutput("expectedFrame", {31'd0, expQ.size() != 0}, 32'd1);
         if (expQ.size() != 0) begin
            monE = expQ.pop_front();
            checkOutput("dOut", {24'd0, d_out}, {24'd0, monE.data});
            checkOutput("frameErr", {31'd0, frame_err}, {31'd0, monE.fe});
            checkOutput("parityErr", {31'd0, parity_err}, {31'd0, monE.pe});
            checkOutput("overrun", {31'd0, overrun}, {31'd0, monE.ov});
            checkOutput("rxReady", {31'd0, rx_ready}, 32'd1);
         end
      end
      prevValid = rx_valid;
   end

   // Drives one frame; abortBit < 11 returns halfway through that bit
   task automatic sendFrame(input logic [7:0] data, input logic parBit, input logic stopBit,
                            input int bitClk, input int abortBit, input int gapClk);
      logic [10:0] bits;
      bits = {stopBit, parBit, data, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rxd = bits[i];
         if (i == abortBit) begin
            repeat (bitClk / 2) @(negedge clk);
            return;
         end
         repeat (bitClk) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (gapClk) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic parBit, input logic stopBit,
                                input int bitClk, input int gapClk);
      exp_t e;
      e.data = data;
      e.fe   = ~stopBit;
      e.pe   = ((($countones(data) + int'(parBit)) % 2) == 1) != PARITY_ODD;
      e.ov   = pending;
      expQ.push_back(e);
      pending = 1'b1;
      sendFrame(data, parBit, stopBit, bitClk, 11, gapClk);
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drainTimeout", expQ.size(), 0);
      repeat (4) @(negedge clk);
      checkOutput("idleReceiving", {31'd0, receiving}, 32'd0);
   endtask

   task automatic doAck();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      pending = 1'b0;
      checkOutput("ackReady", {31'd0, rx_ready}, 32'd0);
      checkOutput("ackOverrun", {31'd0, overrun}, 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Dout"}, {24'd0, d_out}, 32'd0);
      checkOutput({tag, "Flags"}, {25'd0, rx_valid, rx_ready, receiving, frame_err,
                                  parity_err, overrun, 1'b0}, 32'd0);
   endtask

   initial begin
      logic [7:0] rData;
      logic       rPar;
      logic       rStop;
      int         rClk;
      rst_n = 1'b0;
      rxd = 1'b1;
      enable_rx = 1'b1;
      rx_ack = 1'b0;
      repeat (5) @(negedge clk);
      checkResetOutputs("inReset");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkResetOutputs("afterReset");

      applyStimulus(8'hA5, 1'b0, 1'b1, 64, 16);
      waitDrain();
      doAck();

      applyStimulus(8'h3C, 1'b1, 1'b1, 64, 16);
      waitDrain();
      doAck();
      applyStimulus(8'h81, 1'b0, 1'b0, 64, 16);
      waitDrain();
      doAck();

      // Glitch: 5 ticks low is a false start
      repeat (40) @(negedge clk);
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rcvNotYet", {31'd0, receiving}, 32'd0);
      @(negedge clk);
      checkOutput("rcvRise", {31'd0, receiving}, 32'd1);
      repeat (17) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("glitchDrop", {31'd0, receiving}, 32'd0);
      applyStimulus(8'h55, 1'b0, 1'b1, 64, 16);
      waitDrain();
      doAck();

      applyStimulus(8'h11, 1'b0, 1'b1, 64, 0);
      applyStimulus(8'h22, 1'b0, 1'b1, 64, 16);
      waitDrain();
      checkOutput("b2bOverrun", {31'd0, overrun}, 32'd1);
      doAck();

      // Baud skew of about +/-3% at clk resolution
      applyStimulus(8'hF0, 1'b0, 1'b1, 62, 16);
      waitDrain();
      doAck();
      applyStimulus(8'hF0, 1'b0, 1'b1, 66, 16);
      waitDrain();

      sendFrame(8'h99, 1'b0, 1'b1, 64, 5, 0);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midReset");
      pending = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (400) @(negedge clk);
      applyStimulus(8'h7E, 1'b0, 1'b1, 64, 16);
      waitDrain();
      doAck();

      sendFrame(8'h99, 1'b0, 1'b1, 64, 5, 0);
      enable_rx = 1'b0;
      @(negedge clk);
      checkOutput("disRcv", {31'd0, receiving}, 32'd0);
      checkOutput("disKeepDout", {24'd0, d_out}, 32'h7E);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      enable_rx = 1'b1;
      repeat (400) @(negedge clk);
      applyStimulus(8'h7E, 1'b0, 1'b1, 64, 16);
      waitDrain();
      doAck();

      // Break: line held low for 12 bit times
      begin
         exp_t e;
         e.data = 8'h00;
         e.fe = 1'b1;
         e.pe = 1'b0;
         e.ov = pending;
         expQ.push_back(e);
         pending = 1'b1;
      end
      rxd = 1'b0;
      repeat (12 * 64) @(negedge clk);
      rxd = 1'b1;
      repeat (16) @(negedge clk);
      waitDrain();
      doAck();

      for (int i = 0; i < 12; i++) begin
         rData = 8'($urandom);
         rPar  = 1'(($countones(rData) % 2) != 0) ^ PARITY_ODD;
         if ($urandom_range(0, 3) == 0) rPar = ~rPar;
         rStop = ($urandom_range(0, 4) != 0);
         case ($urandom_range(0, 2))
            0: rClk = 62;
            1: rClk = 64;
            default: rClk = 66;
         endcase
         applyStimulus(rData, rPar, rStop, rClk, 16 + int'($urandom_range(0, 40)));
         waitDrain();
         if ($urandom_range(0, 2) != 0) doAck();
      end

      repeat (50) @(negedge clk);
      checkOutput("queueEmpty", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
